fir_coef_loader: RTL and testbench

Coefficient reload controller sitting directly upstream of the fir91 reloadable-coefficient port. A host fills an internal staging buffer of NUM_COEF coefficients, then commits. The block streams the buffer into the FIR's inactive coefficient set and switches the FIR's active set (`coef_set`) only at a gap in the input data stream, so no sample is filtered with a partially loaded set.

---
 rtl/fir_coef_loader.sv | 110 +++++++++++
 tb/tb_fir_coef_loader.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fir_coef_loader.sv
// Stages NUM_COEF coefficients from a host, streams them into the FIR's inactive set,
// then flips coef_set at the first sink_valid gap so no sample sees a half-loaded set.
module fir_coef_loader #(
  parameter int COEF_WIDTH = 19,
  parameter int NUM_COEF   = 80,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  host_wr,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [COEF_WIDTH-1:0] host_data,
  input  logic                  host_commit,
  input  logic                  sink_valid,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  coef_set,
  output logic                  coef_set_in,
  output logic                  coef_we,
  output logic [COEF_WIDTH-1:0] coef_in
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, WAIT_GAP} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_COEF - 1);
  // One bit wider so NUM_COEF is representable even when 2**ADDR_WIDTH == NUM_COEF.
  localparam logic [ADDR_WIDTH:0]   NUM_C     = (ADDR_WIDTH + 1)'(NUM_COEF);

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt;
  logic                  last_rd;
  logic                  rd_vld;
  logic [COEF_WIDTH-1:0] rd_data;
  logic [COEF_WIDTH-1:0] mem [NUM_COEF];
  logic                  commit_ok;
  logic                  rd_en;
  logic                  wr_ok;
  logic                  switch_now;

  always_comb begin
    state_nxt  = state;
    commit_ok  = 1'b0;
    rd_en      = 1'b0;
    switch_now = 1'b0;
    case (state)
      IDLE: begin
        if (host_commit) begin
          commit_ok = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        // Stay one extra cycle after the last read so its data reaches coef_in.
        if (!last_rd) rd_en = 1'b1;
        else          state_nxt = DRAIN;
      end
      DRAIN: state_nxt = WAIT_GAP;
      WAIT_GAP: begin
        if (!sink_valid) begin
          switch_now = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy        = (state != IDLE);
  assign coef_set_in = ~coef_set;
  assign wr_ok       = host_wr && (state == IDLE) && ({1'b0, host_addr} < NUM_C);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[host_addr] <= host_data;
    if (rd_en) rd_data <= mem[cnt];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      last_rd  <= 1'b0;
      rd_vld   <= 1'b0;
      coef_we  <= 1'b0;
      coef_in  <= '0;
      coef_set <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state  <= state_nxt;
      rd_vld <= rd_en;
      done   <= switch_now;
      coef_we <= rd_vld;
      if (rd_vld)     coef_in  <= rd_data;
      if (switch_now) coef_set <= ~coef_set;
      if (commit_ok) begin
        cnt     <= '0;
        last_rd <= 1'b0;
        err     <= 1'b0;
      end else begin
        if (rd_en) begin
          cnt     <= cnt + 1'b1;
          last_rd <= (cnt == LAST_ADDR);
        end
        if (busy && (host_commit || host_wr)) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fir_coef_loader.sv
// Drives host writes/commits and checks the FIR coefficient stream and set switch against a model.
module tb_fir_coef_loader;
  localparam int NC = 80;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        host_wr;
  logic [6:0]  host_addr;
  logic [18:0] host_data;
  logic        host_commit;
  logic        sink_valid;
  logic        busy, done, err, coef_set, coef_set_in, coef_we;
  logic [18:0] coef_in;

  int checks   = 0;
  int failures = 0;
  int stage[NC];
  bit exp_err;
  bit exp_set;

  typedef struct {
    int addr;
    int data;
    bit exp_err;
  } wv_t;
  wv_t tbl[6];

  always #5 clk = ~clk;

  fir_coef_loader dut (
    .clk(clk), .reset_n(reset_n), .host_wr(host_wr), .host_addr(host_addr),
    .host_data(host_data), .host_commit(host_commit), .sink_valid(sink_valid),
    .busy(busy), .done(done), .err(err), .coef_set(coef_set),
    .coef_set_in(coef_set_in), .coef_we(coef_we), .coef_in(coef_in)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input int a, input int d);
    host_wr   = 1'b1;
    host_addr = 7'(a);
    host_data = 19'(d);
    if (a < NC) stage[a] = int'($signed(19'(d)));
    tick();
    host_wr = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_coef_set"}, coef_set, 0);
    chk({tag, "_coef_set_in"}, coef_set_in, 1);
    chk({tag, "_coef_we"}, coef_we, 0);
    chk({tag, "_coef_in"}, longint'(coef_in), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Expected behaviour: commit at E0, stream stage[k] after E(k+2), switch at the first
  // edge >= NC+3 that samples sink_valid low.
  task automatic run_load(input int inj_edge, input int sv_mode, input int sv_until, input bit sim_wr);
    bit sv[400];
    int snap[NC];
    int sw;
    bit set_now;
    bit we_exp;
    for (int n = 0; n < 400; n++)
      sv[n] = (sv_mode == 0) ? (n <= sv_until) : (n < 250 && $urandom_range(0, 3) != 0);
    sw = -1;
    for (int n = NC + 3; n < 400; n++)
      if (!sv[n] && sw < 0) sw = n;
    host_commit = 1'b1;
    sink_valid  = sv[0];
    if (sim_wr) begin
      host_wr   = 1'b1;
      host_addr = 7'd79;
      host_data = 19'(-79);
      stage[79] = -79;
    end
    snap = stage;
    tick();
    host_commit = 1'b0;
    host_wr     = 1'b0;
    exp_err     = 1'b0;
    chk("commit_busy", busy, 1);
    chk("commit_err", err, 0);
    chk("commit_we", coef_we, 0);
    for (int n = 1; n <= sw; n++) begin
      sink_valid = sv[n];
      if (n == inj_edge) begin
        host_commit = 1'b1;
        host_wr     = 1'b1;
        host_addr   = 7'd5;
        host_data   = 19'd777;
      end
      tick();
      host_commit = 1'b0;
      host_wr     = 1'b0;
      if (n == inj_edge) exp_err = 1'b1;
      we_exp  = (n >= 2 && n <= NC + 1);
      set_now = (n >= sw) ? !exp_set : exp_set;
      chk("coef_we", coef_we, we_exp);
      if (we_exp)         chk("coef_in", longint'($signed(coef_in)), snap[n-2]);
      else if (n > NC + 1) chk("coef_in_hold", longint'($signed(coef_in)), snap[NC-1]);
      chk("coef_set", coef_set, set_now);
      chk("coef_set_in", coef_set_in, !set_now);
      chk("done", done, n == sw);
      chk("busy", busy, n < sw);
      chk("err", err, exp_err);
    end
    exp_set = !exp_set;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; host_wr = 1'b0; host_addr = '0; host_data = '0;
    host_commit = 1'b0; sink_valid = 1'b0; exp_set = 1'b0; exp_err = 1'b0;
    #2;
    chk_reset_vals("rst0");
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Basic load, negatives included, sink_valid low throughout.
    for (int k = 0; k < NC; k++) host_write(k, 3 * k - 100);
    run_load(-1, 0, -1, 1'b0);

    // Second bank; last write coincides with the commit.
    for (int k = 0; k < NC - 1; k++) host_write(k, -k);
    run_load(-1, 0, -1, 1'b1);

    // Back-to-back commit with sink_valid busy through E200.
    run_load(-1, 0, 200, 1'b0);

    tbl[0] = '{100, 777, 1'b0};
    tbl[1] = '{127, -5, 1'b0};
    tbl[2] = '{80, 1, 1'b0};
    tbl[3] = '{0, 12345, 1'b0};
    tbl[4] = '{79, -262144, 1'b0};
    tbl[5] = '{5, -1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      host_write(tbl[i].addr, tbl[i].data);
      chk("idle_wr_err", err, tbl[i].exp_err);
      chk("idle_wr_busy", busy, 0);
    end

    // Commit and write pulsed while cnt=40; staging[5] must keep -1.
    run_load(41, 0, -1, 1'b0);
    run_load(-1, 1, 0, 1'b0);

    for (int k = 0; k < NC; k++) host_write(k, int'($urandom_range(0, 524287)));
    run_load(-1, 1, 0, 1'b0);

    // Reset while coefficient 40 is on the bus.
    host_commit = 1'b1;
    tick();
    host_commit = 1'b0;
    for (int n = 1; n <= 42; n++) begin
      sink_valid = 1'($urandom_range(0, 1));
      tick();
    end
    chk("midload_we", coef_we, 1);
    chk("midload_coef", longint'($signed(coef_in)), stage[40]);
    reset_n     = 1'b0;
    host_commit = 1'($urandom_range(0, 1));
    sink_valid  = 1'($urandom_range(0, 1));
    #1;
    chk_reset_vals("rst_mid");
    tick();
    reset_n = 1'b1;
    host_commit = 1'b0;
    sink_valid  = 1'b0;
    exp_set = 1'b0;
    tick();
    run_load(-1, 0, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
